// File: rtl/gb_vram_pkg.sv
// Shared definitions for the banked video-RAM: LCD mode encodings,
// CPU access FSM states and the bank-select width helper.
package gb_vram_pkg;

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_WAIT,
        CPU_ACCESS,
        CPU_ACK
    } cpu_state_t;

    // A single bank still carries a one-bit register so VBK readback stays uniform.
    function automatic int bank_w(input int num_banks);
        if (num_banks <= 2) begin
            return 1;
        end
        return $clog2(num_banks);
    endfunction

endpackage

// File: rtl/vram_bank_ram.sv
// Single-port synchronous RAM for one VRAM bank; read data is registered
// and reflects the contents before any write in the same cycle.
module vram_bank_ram
    import gb_vram_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= di;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/vram_bank_arbiter.sv
// Banked VRAM shared by the CPU (req/ack handshake, VBK bank select) and the
// video fetcher, which always wins; CPU access is refused during LCD mode 3.
module vram_bank_arbiter
    import gb_vram_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int NUM_BANKS   = 2,
    parameter int BLOCK_MODE3 = 1
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_di,
    output logic [DATA_W-1:0]           cpu_do,
    output logic                        cpu_ack,
    input  logic                        vbk_wr,
    input  logic [DATA_W-1:0]           vbk_di,
    output logic [DATA_W-1:0]           vbk_do,
    input  logic                        vid_req,
    input  logic [ADDR_W-1:0]           vid_addr,
    output logic [NUM_BANKS*DATA_W-1:0] vid_do,
    output logic                        vid_valid,
    input  logic                        lcd_on,
    input  logic [1:0]                  lcd_mode
);

    localparam int BANK_W = bank_w(NUM_BANKS);

    cpu_state_t        state_q;
    cpu_state_t        state_d;
    logic [BANK_W-1:0] bank_q;
    logic [BANK_W-1:0] acc_bank_q;
    logic              blocked;
    logic              cpu_issue;
    logic              blocked_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [NUM_BANKS-1:0] ram_we;
    logic [DATA_W-1:0] ram_rd [NUM_BANKS];
    logic [DATA_W-1:0] acc_rd;
    logic              vid_pend_q;
    logic              vbk_unused;

    assign blocked    = (BLOCK_MODE3 != 0) && lcd_on && (lcd_mode == MODE_XFER);
    assign cpu_ack    = (state_q == CPU_ACK);
    assign vbk_do     = {{(DATA_W - BANK_W){1'b1}}, bank_q};
    assign vbk_unused = ^vbk_di[DATA_W-1:BANK_W];

    // The CPU only issues when video is idle, so one shared address bus suffices.
    assign ram_addr = vid_req ? vid_addr : cpu_addr;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign ram_we[b] = cpu_issue && cpu_we && (bank_q == BANK_W'(b));

            vram_bank_ram #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_ram (
                .clk  (clk_sys),
                .we   (ram_we[b]),
                .addr (ram_addr),
                .di   (cpu_di),
                .dout (ram_rd[b])
            );
        end
    endgenerate

    always_comb begin
        acc_rd = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (acc_bank_q == BANK_W'(b)) begin
                acc_rd = ram_rd[b];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CPU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_issue    = 1'b0;
        blocked_done = 1'b0;
        case (state_q)
            CPU_IDLE, CPU_WAIT: begin
                if (!cpu_req) begin
                    state_d = CPU_IDLE;
                end else if (blocked) begin
                    state_d      = CPU_ACK;
                    blocked_done = 1'b1;
                end else if (vid_req) begin
                    state_d = CPU_WAIT;
                end else begin
                    state_d   = CPU_ACCESS;
                    cpu_issue = 1'b1;
                end
            end
            CPU_ACCESS: state_d = CPU_ACK;
            CPU_ACK:    state_d = CPU_IDLE;
            default:    state_d = CPU_IDLE;
        endcase
    end

    // The bank is latched at issue so a concurrent VBK write cannot redirect the read.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bank_q     <= '0;
            acc_bank_q <= '0;
            cpu_do     <= '0;
        end else begin
            if (vbk_wr) begin
                bank_q <= vbk_di[BANK_W-1:0];
            end
            if (cpu_issue) begin
                acc_bank_q <= bank_q;
            end
            if (blocked_done && !cpu_we) begin
                cpu_do <= '1;
            end else if ((state_q == CPU_ACCESS) && !cpu_we) begin
                cpu_do <= acc_rd;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vid_pend_q <= 1'b0;
            vid_valid  <= 1'b0;
            vid_do     <= '0;
        end else begin
            vid_pend_q <= vid_req;
            vid_valid  <= vid_pend_q;
            if (vid_pend_q) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    vid_do[b*DATA_W +: DATA_W] <= ram_rd[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_bank_arbiter.sv
// Directed bench for vram_bank_arbiter: a vector table of CPU accesses plus
// hand-written sequences for video, contention, lockout, back-to-back and reset.
module tb_vram_bank_arbiter;
    import gb_vram_pkg::*;

    logic        clk_sys;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_ack;
    logic        vbk_wr;
    logic [7:0]  vbk_di;
    logic [7:0]  vbk_do;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [15:0] vid_do;
    logic        vid_valid;
    logic        lcd_on;
    logic [1:0]  lcd_mode;

    logic        nb_req;
    logic        nb_we;
    logic [12:0] nb_addr;
    logic [7:0]  nb_di;
    logic [7:0]  nb_do;
    logic        nb_ack;
    logic [7:0]  nb_vbk_do;
    logic [15:0] nb_vid_do;
    logic        nb_vid_valid;

    int checks = 0;
    int errors = 0;

    vram_bank_arbiter #(
        .ADDR_W(13), .DATA_W(8), .NUM_BANKS(2), .BLOCK_MODE3(1)
    ) u_dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_di    (cpu_di),
        .cpu_do    (cpu_do),
        .cpu_ack   (cpu_ack),
        .vbk_wr    (vbk_wr),
        .vbk_di    (vbk_di),
        .vbk_do    (vbk_do),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_do    (vid_do),
        .vid_valid (vid_valid),
        .lcd_on    (lcd_on),
        .lcd_mode  (lcd_mode)
    );

    // Second instance without the mode-3 lockout, driven by its own CPU port.
    vram_bank_arbiter #(
        .ADDR_W(13), .DATA_W(8), .NUM_BANKS(2), .BLOCK_MODE3(0)
    ) u_dut_nb (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cpu_req   (nb_req),
        .cpu_we    (nb_we),
        .cpu_addr  (nb_addr),
        .cpu_di    (nb_di),
        .cpu_do    (nb_do),
        .cpu_ack   (nb_ack),
        .vbk_wr    (1'b0),
        .vbk_di    (8'h00),
        .vbk_do    (nb_vbk_do),
        .vid_req   (1'b0),
        .vid_addr  (13'h0000),
        .vid_do    (nb_vid_do),
        .vid_valid (nb_vid_valid),
        .lcd_on    (lcd_on),
        .lcd_mode  (lcd_mode)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  vbk_raw;
        logic [7:0]  exp_vbk;
        logic        lcd_on;
        logic [1:0]  mode;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  di;
        int          exp_lat;
        logic [7:0]  exp_do;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setBank(input logic [7:0] v);
        @(negedge clk_sys);
        vbk_wr = 1'b1;
        vbk_di = v;
        @(negedge clk_sys);
        vbk_wr = 1'b0;
    endtask

    // Full CPU transaction; lat counts edges from request until cpu_ack is seen.
    task automatic applyStimulus(input logic we, input logic [12:0] addr, input logic [7:0] di,
                                 input logic vbk_same, input logic [7:0] vbk_val,
                                 output int lat, output logic [7:0] rdata);
        @(negedge clk_sys);
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_di   = di;
        if (vbk_same) begin
            vbk_wr = 1'b1;
            vbk_di = vbk_val;
        end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            vbk_wr = 1'b0;
            lat++;
            if (cpu_ack) break;
        end
        rdata   = cpu_do;
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        logic [7:0] rd;

        vecs[0]  = '{8'hF1, 8'hFF, 1'b1, MODE_HBLANK, 1'b1, 13'h0010, 8'hA5, 2, 8'h00};
        vecs[1]  = '{8'h00, 8'hFE, 1'b1, MODE_HBLANK, 1'b1, 13'h0010, 8'h3C, 2, 8'h00};
        vecs[2]  = '{8'h03, 8'hFF, 1'b1, MODE_HBLANK, 1'b0, 13'h0010, 8'h00, 2, 8'hA5};
        vecs[3]  = '{8'hFE, 8'hFE, 1'b1, MODE_HBLANK, 1'b0, 13'h0010, 8'h00, 2, 8'h3C};
        vecs[4]  = '{8'h00, 8'hFE, 1'b1, MODE_VBLANK, 1'b1, 13'h0020, 8'h11, 2, 8'h3C};
        vecs[5]  = '{8'h00, 8'hFE, 1'b1, MODE_XFER,   1'b1, 13'h0020, 8'h77, 1, 8'h3C};
        vecs[6]  = '{8'h00, 8'hFE, 1'b1, MODE_HBLANK, 1'b0, 13'h0020, 8'h00, 2, 8'h11};
        vecs[7]  = '{8'h00, 8'hFE, 1'b1, MODE_XFER,   1'b0, 13'h0010, 8'h00, 1, 8'hFF};
        vecs[8]  = '{8'h01, 8'hFF, 1'b0, MODE_XFER,   1'b1, 13'h0030, 8'h22, 2, 8'hFF};
        vecs[9]  = '{8'h01, 8'hFF, 1'b0, MODE_XFER,   1'b0, 13'h0030, 8'h00, 2, 8'h22};
        vecs[10] = '{8'h01, 8'hFF, 1'b1, MODE_OAM,    1'b1, 13'h1FFF, 8'hC3, 2, 8'h22};
        vecs[11] = '{8'h01, 8'hFF, 1'b1, MODE_VBLANK, 1'b0, 13'h1FFF, 8'h00, 2, 8'hC3};
        vecs[12] = '{8'h00, 8'hFE, 1'b1, MODE_VBLANK, 1'b0, 13'h0020, 8'h00, 2, 8'h11};

        reset_n  = 1'b0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_di   = '0;
        vbk_wr   = 1'b0;
        vbk_di   = '0;
        vid_req  = 1'b0;
        vid_addr = '0;
        lcd_on   = 1'b0;
        lcd_mode = MODE_HBLANK;
        nb_req   = 1'b0;
        nb_we    = 1'b0;
        nb_addr  = '0;
        nb_di    = '0;

        repeat (3) @(negedge clk_sys);
        checkOutput("reset_cpu_ack", cpu_ack, 1'b0);
        checkOutput("reset_cpu_do", cpu_do, 8'h00);
        checkOutput("reset_vid_valid", vid_valid, 1'b0);
        checkOutput("reset_vid_do", vid_do, 16'h0000);
        checkOutput("reset_vbk_do", vbk_do, 8'hFE);
        checkOutput("reset_nb_vbk_do", nb_vbk_do, 8'hFE);
        checkOutput("reset_nb_vid_do", nb_vid_do, 16'h0000);
        checkOutput("reset_nb_vid_valid", nb_vid_valid, 1'b0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            lcd_on   = vecs[i].lcd_on;
            lcd_mode = vecs[i].mode;
            setBank(vecs[i].vbk_raw);
            checkOutput($sformatf("vec%0d_vbk_do", i), vbk_do, vecs[i].exp_vbk);
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].di, 1'b0, 8'h00, lat, rd);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d_cpu_do", i), rd, vecs[i].exp_do);
        end

        $display("[TB] video read of both banks");
        lcd_on   = 1'b1;
        lcd_mode = MODE_HBLANK;
        @(negedge clk_sys);
        vid_req  = 1'b1;
        vid_addr = 13'h0010;
        @(negedge clk_sys);
        vid_req = 1'b0;
        checkOutput("vid_valid_early", vid_valid, 1'b0);
        @(negedge clk_sys);
        checkOutput("vid_valid_pulse", vid_valid, 1'b1);
        checkOutput("vid_do_banks", vid_do, 16'hA53C);
        @(negedge clk_sys);
        checkOutput("vid_valid_drop", vid_valid, 1'b0);
        checkOutput("vid_do_hold", vid_do, 16'hA53C);

        $display("[TB] contention with video");
        setBank(8'h00);
        @(negedge clk_sys);
        vid_req  = 1'b1;
        vid_addr = 13'h0010;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0010;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_sys);
            checkOutput($sformatf("wait_no_ack_%0d", i), cpu_ack, 1'b0);
        end
        vid_req = 1'b0;
        @(negedge clk_sys);
        checkOutput("wait_access_no_ack", cpu_ack, 1'b0);
        @(negedge clk_sys);
        checkOutput("wait_ack", cpu_ack, 1'b1);
        checkOutput("wait_cpu_do", cpu_do, 8'h3C);
        cpu_req = 1'b0;
        checkOutput("wait_vid_do", vid_do, 16'hA53C);

        $display("[TB] mode 3 begins while waiting");
        lcd_on   = 1'b1;
        lcd_mode = MODE_OAM;
        @(negedge clk_sys);
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0020;
        @(negedge clk_sys);
        checkOutput("mchg_no_ack_1", cpu_ack, 1'b0);
        @(negedge clk_sys);
        checkOutput("mchg_no_ack_2", cpu_ack, 1'b0);
        lcd_mode = MODE_XFER;
        @(negedge clk_sys);
        checkOutput("mchg_ack", cpu_ack, 1'b1);
        checkOutput("mchg_cpu_do", cpu_do, 8'hFF);
        cpu_req  = 1'b0;
        vid_req  = 1'b0;
        lcd_mode = MODE_HBLANK;
        applyStimulus(1'b0, 13'h0020, 8'h00, 1'b0, 8'h00, lat, rd);
        checkOutput("mchg_reread", rd, 8'h11);

        $display("[TB] VBK write alongside accepted access");
        setBank(8'h01);
        applyStimulus(1'b1, 13'h0060, 8'h0F, 1'b0, 8'h00, lat, rd);
        setBank(8'h00);
        applyStimulus(1'b1, 13'h0060, 8'hE1, 1'b1, 8'h01, lat, rd);
        checkOutput("vbk_same_latency", lat, 2);
        checkOutput("vbk_same_vbk_do", vbk_do, 8'hFF);
        applyStimulus(1'b0, 13'h0060, 8'h00, 1'b0, 8'h00, lat, rd);
        checkOutput("vbk_same_bank1", rd, 8'h0F);
        setBank(8'h00);
        applyStimulus(1'b0, 13'h0060, 8'h00, 1'b0, 8'h00, lat, rd);
        checkOutput("vbk_same_bank0", rd, 8'hE1);

        $display("[TB] back-to-back without mode-3 lockout");
        lcd_on   = 1'b1;
        lcd_mode = MODE_XFER;
        @(negedge clk_sys);
        nb_req  = 1'b1;
        nb_we   = 1'b1;
        nb_addr = 13'h0040;
        nb_di   = 8'h5A;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            lat++;
            if (nb_ack) break;
        end
        checkOutput("b2b_write_latency", lat, 2);
        nb_we = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            lat++;
            if (nb_ack) break;
        end
        checkOutput("b2b_read_latency", lat, 3);
        checkOutput("b2b_read_data", nb_do, 8'h5A);
        nb_req   = 1'b0;
        lcd_mode = MODE_HBLANK;

        $display("[TB] reset during ACCESS");
        setBank(8'h01);
        @(negedge clk_sys);
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 13'h0050;
        cpu_di   = 8'h99;
        @(negedge clk_sys);
        checkOutput("rst_in_access_no_ack", cpu_ack, 1'b0);
        reset_n  = 1'b0;
        cpu_req  = 1'b0;
        vid_req  = 1'b1;
        vid_addr = 13'h0010;
        #1;
        checkOutput("rst_mid_cpu_ack", cpu_ack, 1'b0);
        checkOutput("rst_mid_vid_valid", vid_valid, 1'b0);
        checkOutput("rst_mid_vbk_do", vbk_do, 8'hFE);
        checkOutput("rst_mid_cpu_do", cpu_do, 8'h00);
        checkOutput("rst_mid_vid_do", vid_do, 16'h0000);
        @(negedge clk_sys);
        checkOutput("rst_hold_vid_valid", vid_valid, 1'b0);
        vid_req = 1'b0;
        reset_n = 1'b1;
        @(negedge clk_sys);
        checkOutput("rst_release_no_ack", cpu_ack, 1'b0);
        applyStimulus(1'b0, 13'h0010, 8'h00, 1'b0, 8'h00, lat, rd);
        checkOutput("rst_keep_bank0", rd, 8'h3C);
        setBank(8'h01);
        applyStimulus(1'b0, 13'h0050, 8'h00, 1'b0, 8'h00, lat, rd);
        checkOutput("rst_committed_write", rd, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_bank_arbiter.md
Name: vram_bank_arbiter

Overview:
- Banked video-RAM store with a single-port synchronous RAM per bank, shared by the CPU and the video fetcher.
- Replaces the fixed two-bank VRAM with address mux: bank count, address width and data width are parameters.
- Adds a CPU request/ack handshake, video-priority arbitration, LCD mode-3 access lockout and a VBK-style bank-select register.
- Sits between the CPU bus decoder and the video unit.

Parameters:
- ADDR_W, 13, byte address width per bank (depth 2^ADDR_W).
- DATA_W, 8, data width.
- NUM_BANKS, 2, bank count; power of two, >= 1.
- BLOCK_MODE3, 1, when 1 CPU access is locked out while the LCD is on in mode 3.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_di  in  DATA_W  CPU write data.
- cpu_do  out  DATA_W  CPU read data; valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- vbk_wr  in  1  write strobe for the bank-select register.
- vbk_di  in  DATA_W  bank-select write data.
- vbk_do  out  DATA_W  bank-select readback.
- vid_req  in  1  video read request; one access per cycle.
- vid_addr  in  ADDR_W  video address.
- vid_do  out  NUM_BANKS*DATA_W  all banks at vid_addr; bank b occupies bits [b*DATA_W +: DATA_W].
- vid_valid  out  1  vid_do valid.
- lcd_on  in  1  LCD enabled.
- lcd_mode  in  2  0 hblank, 1 vblank, 2 OAM scan, 3 transfer.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - state=IDLE; cpu_ack=0; cpu_do=0; vid_valid=0; vid_do=0.
  - Bank register=0, so vbk_do={ones, 0}.
  - RAM contents are not cleared.
- Bank register:
  - Width BANK_W=max(1, clog2(NUM_BANKS)).
  - vbk_wr loads vbk_di[BANK_W-1:0]; upper bits of vbk_di are ignored.
  - vbk_do = all upper bits 1, low BANK_W bits = register value (NUM_BANKS=2: 0xFE or 0xFF).
  - vbk_wr in the same cycle as an accepted CPU access: the access uses the old bank value.
- Video port:
  - vid_req at edge N performs a read of every bank at vid_addr.
  - At edge N+1, vid_do is updated and vid_valid=1 for exactly one cycle per request.
  - vid_do holds its value when no request is present.
  - Video is never stalled and always wins arbitration.
- Blocked = BLOCK_MODE3 && lcd_on && lcd_mode==3. It is evaluated in every IDLE and WAIT cycle.
- CPU FSM states are IDLE, WAIT, ACCESS and ACK.
- IDLE:
  - cpu_req && blocked -> ACK. A read returns all-ones; a write is dropped; no RAM access occurs.
  - cpu_req && !blocked && vid_req -> WAIT.
  - cpu_req && !blocked && !vid_req -> ACCESS. The RAM op on the selected bank happens this cycle: the write commits, or the read is issued.
- WAIT:
  - Same decision as IDLE each cycle.
  - Stays in WAIT while vid_req=1 and the access is not blocked.
  - If mode 3 begins while waiting, the CPU access completes as blocked.
- ACCESS: for a read, capture the RAM output into cpu_do; then -> ACK.
- ACK: cpu_ack=1 for exactly one cycle; then -> IDLE.
- Latency:
  - Uncontended access: cpu_ack is high 2 edges after acceptance (IDLE->ACCESS->ACK).
  - Blocked access: cpu_ack after 1 edge.
- Handshake rules:
  - cpu_addr, cpu_we and cpu_di must stay stable from cpu_req rise until cpu_ack.
  - The requester drops cpu_req on the edge where it samples cpu_ack=1.
  - cpu_req still high in the IDLE cycle after ACK is treated as a new request.
- cpu_do holds its last value outside ACK. Write acks leave cpu_do unchanged.
- Each bank RAM has one access per cycle; the video and CPU never touch a bank in the same cycle.
- Addresses wrap naturally at 2^ADDR_W; there are no out-of-range cases.
- Reset asserted mid-operation: any in-flight write that has not yet reached ACCESS is lost; the FSM returns to IDLE; no spurious ack is produced.

Decomposition:
- Package gb_vram_pkg holds:
  - LCD mode constants: MODE_HBLANK=0, MODE_VBLANK=1, MODE_OAM=2, MODE_XFER=3.
  - The CPU FSM state enum.
  - A BANK_W function.
- Sub-module vram_bank_ram:
  - Single-port synchronous RAM: we, addr, di, registered do.
  - Instantiated NUM_BANKS times through generate.

Test Plan:
- Reset: reset_n=0 mid-ACCESS -> cpu_ack=0, vid_valid=0, vbk_do=0xFE; RAM byte written earlier is still readable after release.
- Banking: vbk_di=0x01, CPU writes 0xA5 at 0x0010; vbk_di=0x00, CPU writes 0x3C at 0x0010; vid_req at 0x0010 -> vid_do=0xA53C, vid_valid pulses one cycle.
- Contention: vid_req held 4 cycles while cpu_req (read 0x0010, bank 0) -> FSM in WAIT for 4 cycles; cpu_ack 2 edges after vid_req drops; cpu_do=0x3C.
- Lockout: lcd_on=1, lcd_mode=3, CPU write 0x77 to 0x0020 -> ack after 1 edge; a later read in mode 0 returns the prior value. A CPU read in mode 3 -> cpu_do=0xFF.
- Mode change while waiting: CPU read pending in WAIT, lcd_mode switches 2->3 -> ack with 0xFF, no RAM access.
- Back-to-back: cpu_req kept high one cycle after ack -> second access issued; with BLOCK_MODE3=0 in mode 3 -> normal data returned.
